// File: rtl/mem_io_bridge_if.sv
// Bus bundle between the eLC-3 datapath and the memory/IO bridge: the
// datapath request, the SRAM side and the keyboard/display/machine-control pins.
interface mem_io_bridge_if;
    logic        Mem_En;
    logic        Mem_WE;
    logic [15:0] Address;
    logic [15:0] Data_In;
    logic [15:0] Data_Out;
    logic        Ready;
    logic [15:0] Sram_Addr;
    logic [15:0] Sram_Wdata;
    logic [15:0] Sram_Rdata;
    logic        Sram_CE;
    logic        Sram_WE;
    logic        Kb_Valid;
    logic [7:0]  Kb_Data;
    logic [7:0]  Dsp_Data;
    logic        Dsp_Valid;
    logic        Dsp_Ready;
    logic        Kb_Int;
    logic        Run;

    modport master (
        output Mem_En, Mem_WE, Address, Data_In, Sram_Rdata, Kb_Valid, Kb_Data, Dsp_Ready,
        input  Data_Out, Ready, Sram_Addr, Sram_Wdata, Sram_CE, Sram_WE,
               Dsp_Data, Dsp_Valid, Kb_Int, Run
    );

    modport slave (
        input  Mem_En, Mem_WE, Address, Data_In, Sram_Rdata, Kb_Valid, Kb_Data, Dsp_Ready,
        output Data_Out, Ready, Sram_Addr, Sram_Wdata, Sram_CE, Sram_WE,
               Dsp_Data, Dsp_Valid, Kb_Int, Run
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Completes MAR/MDR memory requests against a fixed-latency SRAM or the
// memory-mapped keyboard, display and machine-control registers.
module mem_io_bridge #(
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1,
    parameter logic [15:0] IO_BASE       = 16'hFE00
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_io_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SRAM_WAIT = 2'd1,
        DONE      = 2'd2
    } state_t;

    localparam logic [15:0] KBSR_ADDR = IO_BASE;
    localparam logic [15:0] KBDR_ADDR = IO_BASE + 16'd2;
    localparam logic [15:0] DSR_ADDR  = IO_BASE + 16'd4;
    localparam logic [15:0] DDR_ADDR  = IO_BASE + 16'd6;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
    localparam logic [3:0]  RD_CNT    = 4'(READ_LATENCY);
    localparam logic [3:0]  WR_CNT    = 4'(WRITE_LATENCY);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic        ready_r;
    logic        sram_ce_r;
    logic        sram_we_r;
    logic [15:0] data_out_r;
    logic [15:0] sram_addr_r;
    logic [15:0] sram_wdata_r;
    logic        kb_ready_r;
    logic        kb_ie_r;
    logic [7:0]  kbdr_r;
    logic        dsp_valid_r;
    logic [7:0]  dsp_data_r;
    logic        run_r;

    logic        dev_space_s;
    logic        dev_acc_s;
    logic        kbdr_rd_s;
    logic        kbsr_wr_s;
    logic        ddr_wr_s;
    logic        mcr_wr_s;
    logic [15:0] dev_rdata_s;

    // Device-space decode of the request sampled in IDLE
    always_comb begin
        dev_space_s = (bus.Address >= IO_BASE);
        dev_acc_s   = (state_r == IDLE) && bus.Mem_En && dev_space_s;
        kbdr_rd_s   = dev_acc_s && !bus.Mem_WE && (bus.Address == KBDR_ADDR);
        kbsr_wr_s   = dev_acc_s &&  bus.Mem_WE && (bus.Address == KBSR_ADDR);
        ddr_wr_s    = dev_acc_s &&  bus.Mem_WE && (bus.Address == DDR_ADDR);
        mcr_wr_s    = dev_acc_s &&  bus.Mem_WE && (bus.Address == MCR_ADDR);
        dev_rdata_s = 16'h0000;
        case (bus.Address)
            KBSR_ADDR: dev_rdata_s = {kb_ready_r, kb_ie_r, 14'h0000};
            KBDR_ADDR: dev_rdata_s = {8'h00, kbdr_r};
            DSR_ADDR:  dev_rdata_s = {~dsp_valid_r, 15'h0000};
            MCR_ADDR:  dev_rdata_s = {run_r, 15'h0000};
            default:   dev_rdata_s = 16'h0000;
        endcase
    end

    // Access sequencer: request latch, SRAM strobe, wait counter and Ready pulse
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            we_r         <= 1'b0;
            ready_r      <= 1'b0;
            sram_ce_r    <= 1'b0;
            sram_we_r    <= 1'b0;
            data_out_r   <= 16'h0000;
            sram_addr_r  <= 16'h0000;
            sram_wdata_r <= 16'h0000;
        end else begin
            ready_r   <= 1'b0;
            sram_ce_r <= 1'b0;
            sram_we_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.Mem_En) begin
                        sram_addr_r  <= bus.Address;
                        sram_wdata_r <= bus.Data_In;
                        we_r         <= bus.Mem_WE;
                        if (dev_space_s) begin
                            state_r <= DONE;
                            ready_r <= 1'b1;
                            if (!bus.Mem_WE) begin
                                data_out_r <= dev_rdata_s;
                            end
                        end else begin
                            state_r   <= SRAM_WAIT;
                            sram_ce_r <= 1'b1;
                            sram_we_r <= bus.Mem_WE;
                            cnt_r     <= bus.Mem_WE ? WR_CNT : RD_CNT;
                        end
                    end
                end
                SRAM_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        if (!we_r) begin
                            data_out_r <= bus.Sram_Rdata;
                        end
                        state_r <= DONE;
                        ready_r <= 1'b1;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Device registers and keyboard/display handshakes, live in every state.
    // A KBDR read frees the buffer on the same edge, so a coincident character is kept.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            kb_ready_r  <= 1'b0;
            kb_ie_r     <= 1'b0;
            kbdr_r      <= 8'h00;
            dsp_valid_r <= 1'b0;
            dsp_data_r  <= 8'h00;
            run_r       <= 1'b1;
        end else begin
            if (bus.Kb_Valid && (!kb_ready_r || kbdr_rd_s)) begin
                kbdr_r     <= bus.Kb_Data;
                kb_ready_r <= 1'b1;
            end else if (kbdr_rd_s) begin
                kb_ready_r <= 1'b0;
            end
            if (kbsr_wr_s) begin
                kb_ie_r <= bus.Data_In[14];
            end
            if (mcr_wr_s) begin
                run_r <= bus.Data_In[15];
            end
            if (dsp_valid_r && bus.Dsp_Ready) begin
                dsp_valid_r <= 1'b0;
            end else if (ddr_wr_s && !dsp_valid_r) begin
                dsp_valid_r <= 1'b1;
                dsp_data_r  <= bus.Data_In[7:0];
            end
        end
    end

    assign bus.Data_Out   = data_out_r;
    assign bus.Ready      = ready_r;
    assign bus.Sram_Addr  = sram_addr_r;
    assign bus.Sram_Wdata = sram_wdata_r;
    assign bus.Sram_CE    = sram_ce_r;
    assign bus.Sram_WE    = sram_we_r;
    assign bus.Dsp_Data   = dsp_data_r;
    assign bus.Dsp_Valid  = dsp_valid_r;
    assign bus.Kb_Int     = kb_ready_r & kb_ie_r;
    assign bus.Run        = run_r;
endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: two instances (short and long SRAM latency) driven by
// directed and $urandom transactions, compared with a transaction-level model.
module tb_mem_io_bridge;
    localparam int RL_A = 2, WL_A = 1, RL_B = 4, WL_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel;
    logic        mem_en, mem_we, kb_valid, dsp_ready;
    logic [15:0] addr_d, wdata_d, last_rd;
    logic [7:0]  kb_data;
    logic [15:0] sram_mem [0:65535];
    logic [15:0] ref_mem  [0:65535];
    int          n_checks = 0, n_errors = 0;

    // model state per instance (0 = A, 1 = B)
    logic        m_k15 [2], m_k14 [2], m_run [2], m_dval [2];
    logic [7:0]  m_kbdr [2], m_ddata [2];
    logic [15:0] m_dout [2];
    int          rl [2], wl [2];

    mem_io_bridge_if bus_a ();
    mem_io_bridge_if bus_b ();

    assign bus_a.Mem_En     = mem_en & ~sel;
    assign bus_a.Mem_WE     = mem_we;
    assign bus_a.Address    = addr_d;
    assign bus_a.Data_In    = wdata_d;
    assign bus_a.Sram_Rdata = sram_mem[bus_a.Sram_Addr];
    assign bus_a.Kb_Valid   = kb_valid & ~sel;
    assign bus_a.Kb_Data    = kb_data;
    assign bus_a.Dsp_Ready  = dsp_ready & ~sel;
    assign bus_b.Mem_En     = mem_en & sel;
    assign bus_b.Mem_WE     = mem_we;
    assign bus_b.Address    = addr_d;
    assign bus_b.Data_In    = wdata_d;
    assign bus_b.Sram_Rdata = sram_mem[bus_b.Sram_Addr];
    assign bus_b.Kb_Valid   = kb_valid & sel;
    assign bus_b.Kb_Data    = kb_data;
    assign bus_b.Dsp_Ready  = dsp_ready & sel;

    mem_io_bridge #(.READ_LATENCY(RL_A), .WRITE_LATENCY(WL_A), .IO_BASE(16'hFE00))
        dut_a (.Clk(clk), .Reset(rst_a), .bus(bus_a));
    mem_io_bridge #(.READ_LATENCY(RL_B), .WRITE_LATENCY(WL_B), .IO_BASE(16'hFE00))
        dut_b (.Clk(clk), .Reset(rst_b), .bus(bus_b));

    logic        ready_s, ce_s, swe_s, kbint_s, run_s, dval_s;
    logic [15:0] dout_s, saddr_s, swdata_s;
    logic [7:0]  ddata_s;
    assign ready_s  = sel ? bus_b.Ready      : bus_a.Ready;
    assign ce_s     = sel ? bus_b.Sram_CE    : bus_a.Sram_CE;
    assign swe_s    = sel ? bus_b.Sram_WE    : bus_a.Sram_WE;
    assign kbint_s  = sel ? bus_b.Kb_Int     : bus_a.Kb_Int;
    assign run_s    = sel ? bus_b.Run        : bus_a.Run;
    assign dval_s   = sel ? bus_b.Dsp_Valid  : bus_a.Dsp_Valid;
    assign dout_s   = sel ? bus_b.Data_Out   : bus_a.Data_Out;
    assign saddr_s  = sel ? bus_b.Sram_Addr  : bus_a.Sram_Addr;
    assign swdata_s = sel ? bus_b.Sram_Wdata : bus_a.Sram_Wdata;
    assign ddata_s  = sel ? bus_b.Dsp_Data   : bus_a.Dsp_Data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int s);
        m_k15[s] = 1'b0; m_k14[s] = 1'b0; m_kbdr[s] = 8'h00; m_run[s] = 1'b1;
        m_dval[s] = 1'b0; m_ddata[s] = 8'h00; m_dout[s] = 16'h0000;
    endtask

    // keyboard and display rules for one clock edge
    task automatic model_events(input int s, input logic kbe, input logic [7:0] kbc,
                                input logic kbdr_rd, input logic dr, input logic ddr_wr,
                                input logic [7:0] wch);
        if (kbe && (!m_k15[s] || kbdr_rd)) begin
            m_kbdr[s] = kbc;
            m_k15[s]  = 1'b1;
        end else if (kbdr_rd) begin
            m_k15[s] = 1'b0;
        end
        if (m_dval[s] && dr) begin
            m_dval[s] = 1'b0;
        end else if (ddr_wr && !m_dval[s]) begin
            m_dval[s]  = 1'b1;
            m_ddata[s] = wch;
        end
    endtask

    task automatic model_step(input int s, input logic we, input logic [15:0] a,
                              input logic [15:0] wd, input logic kbe, input logic [7:0] kbc,
                              input logic dr, output logic [15:0] rd);
        rd = 16'h0000;
        if (a < 16'hFE00) begin
            if (we) ref_mem[a] = wd;
            else    rd = ref_mem[a];
            model_events(s, kbe, kbc, 1'b0, dr, 1'b0, 8'h00);
        end else begin
            case (a)
                16'hFE00: begin rd = {m_k15[s], m_k14[s], 14'h0000}; if (we) m_k14[s] = wd[14]; end
                16'hFE02: rd = {8'h00, m_kbdr[s]};
                16'hFE04: rd = {~m_dval[s], 15'h0000};
                16'hFFFE: begin rd = {m_run[s], 15'h0000}; if (we) m_run[s] = wd[15]; end
                default:  rd = 16'h0000;
            endcase
            model_events(s, kbe, kbc, !we && (a == 16'hFE02), dr, we && (a == 16'hFE06), wd[7:0]);
        end
        if (we) rd = 16'h0000;
        else    m_dout[s] = rd;
    endtask

    task automatic check_outputs(input int s);
        chk("kb_int", kbint_s, m_k15[s] & m_k14[s]);
        chk("run", run_s, m_run[s]);
        chk("dsp_valid", dval_s, m_dval[s]);
        chk("dsp_data", ddata_s, m_ddata[s]);
        chk("data_out", dout_s, m_dout[s]);
    endtask

    // one request on the selected instance; starts and ends just after a falling edge
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] wd,
                          input logic kbe, input logic [7:0] kbc, input logic dr);
        int s, n, ce_cnt, ce_at, exp_lat, rcyc;
        logic dev, got;
        logic [15:0] exp_rd, obs_rd;
        s = sel ? 1 : 0;
        dev = (a >= 16'hFE00);
        model_step(s, we, a, wd, kbe, kbc, dr, exp_rd);
        exp_lat = dev ? 1 : ((we ? wl[s] : rl[s]) + 1);
        mem_en = 1'b1; mem_we = we; addr_d = a; wdata_d = wd;
        kb_valid = kbe; kb_data = kbc; dsp_ready = dr;
        n = 0; ce_cnt = 0; ce_at = 0; rcyc = -1; got = 1'b0; obs_rd = 16'h0000;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            kb_valid = 1'b0; dsp_ready = 1'b0;
            if (!dev) chk("sram_addr_stable", saddr_s, a);
            if (ce_s) begin
                ce_cnt++;
                ce_at = n;
                chk("sram_we", swe_s, we);
                if (we) begin
                    chk("sram_wdata", swdata_s, wd);
                    sram_mem[saddr_s] = swdata_s;
                end
            end
            if (ready_s) begin
                got = 1'b1; rcyc = n; obs_rd = dout_s; mem_en = 1'b0;
            end
        end
        mem_en = 1'b0;
        chk("ready_latency", rcyc, exp_lat);
        chk("ce_count", ce_cnt, dev ? 0 : 1);
        if (!dev) chk("ce_cycle", ce_at, 1);
        if (!we) chk("read_data", obs_rd, exp_rd);
        last_rd = obs_rd;
        @(negedge clk);
        chk("ready_one_cycle", ready_s, 1'b0);
        check_outputs(s);
    endtask

    task automatic events(input logic kbe, input logic [7:0] kbc, input logic dr);
        int s;
        logic [15:0] unused_rd;
        s = sel ? 1 : 0;
        unused_rd = 16'h0000;
        kb_valid = kbe; kb_data = kbc; dsp_ready = dr;
        @(negedge clk);
        kb_valid = 1'b0; dsp_ready = 1'b0;
        model_events(s, kbe, kbc, 1'b0, dr, 1'b0, 8'h00);
        check_outputs(s);
    endtask

    initial begin
        logic        seen, r_we, r_kbe, r_dr;
        logic [15:0] r_a, r_wd;
        logic [15:0] dev_list [8];
        int          kind;
        rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
        mem_en = 1'b0; mem_we = 1'b0; addr_d = 16'h0000; wdata_d = 16'h0000;
        kb_valid = 1'b0; kb_data = 8'h00; dsp_ready = 1'b0; last_rd = 16'h0000;
        rl[0] = RL_A; wl[0] = WL_A; rl[1] = RL_B; wl[1] = WL_B;
        model_reset(0); model_reset(1);
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 16'($urandom);
            ref_mem[i]  = sram_mem[i];
        end
        dev_list[0] = 16'hFE00; dev_list[1] = 16'hFE02; dev_list[2] = 16'hFE04;
        dev_list[3] = 16'hFE06; dev_list[4] = 16'hFFFE; dev_list[5] = 16'hFE10;
        dev_list[6] = 16'hFE01; dev_list[7] = 16'hFFFF;

        repeat (3) @(negedge clk);
        chk("rst_ready", bus_a.Ready, 1'b0);
        chk("rst_ce", bus_a.Sram_CE, 1'b0);
        chk("rst_we", bus_a.Sram_WE, 1'b0);
        chk("rst_dout", bus_a.Data_Out, 16'h0000);
        chk("rst_saddr", bus_a.Sram_Addr, 16'h0000);
        chk("rst_swdata", bus_a.Sram_Wdata, 16'h0000);
        chk("rst_dval", bus_a.Dsp_Valid, 1'b0);
        chk("rst_ddata", bus_a.Dsp_Data, 8'h00);
        chk("rst_kbint", bus_a.Kb_Int, 1'b0);
        chk("rst_run", bus_a.Run, 1'b1);
        chk("rst_b_run", bus_b.Run, 1'b1);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        // SRAM read and write, instance A
        sram_mem[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
        access(1'b0, 16'h3000, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("sram_read_1234", last_rd, 16'h1234);
        repeat (2) @(negedge clk);
        chk("dout_held", dout_s, 16'h1234);
        access(1'b1, 16'h0040, 16'hBEEF, 1'b0, 8'h00, 1'b0);
        chk("dout_after_write", dout_s, 16'h1234);
        chk("sram_written", sram_mem[16'h0040], 16'hBEEF);

        // keyboard
        events(1'b1, 8'h41, 1'b0);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("kbsr_8000", last_rd, 16'h8000);
        chk("kbint_off", kbint_s, 1'b0);
        access(1'b1, 16'hFE00, 16'h4000, 1'b0, 8'h00, 1'b0);
        chk("kbint_on", kbint_s, 1'b1);
        events(1'b1, 8'h42, 1'b0);
        access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("kbdr_0041", last_rd, 16'h0041);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("kbsr_4000", last_rd, 16'h4000);
        events(1'b1, 8'h43, 1'b0);
        access(1'b0, 16'hFE02, 16'h0000, 1'b1, 8'h44, 1'b0);
        chk("kbdr_coinc_old", last_rd, 16'h0043);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("kbsr_c000", last_rd, 16'hC000);
        access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("kbdr_coinc_new", last_rd, 16'h0044);

        // display
        access(1'b1, 16'hFE06, 16'h0058, 1'b0, 8'h00, 1'b0);
        chk("ddr_valid", dval_s, 1'b1);
        chk("ddr_data_58", ddata_s, 8'h58);
        access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("dsr_busy", last_rd, 16'h0000);
        access(1'b1, 16'hFE06, 16'h0059, 1'b0, 8'h00, 1'b0);
        chk("ddr_dropped", ddata_s, 8'h58);
        events(1'b0, 8'h00, 1'b1);
        chk("dsp_accepted", dval_s, 1'b0);
        access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("dsr_free", last_rd, 16'h8000);
        access(1'b1, 16'hFE06, 16'h005A, 1'b0, 8'h00, 1'b0);
        access(1'b1, 16'hFE06, 16'h005B, 1'b0, 8'h00, 1'b1);
        chk("ddr_coinc_valid", dval_s, 1'b0);
        chk("ddr_coinc_data", ddata_s, 8'h5A);

        // machine control, unmapped and boundary addresses
        access(1'b1, 16'hFFFE, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("run_low", run_s, 1'b0);
        access(1'b0, 16'hFFFE, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("mcr_read", last_rd, 16'h0000);
        access(1'b1, 16'hFFFE, 16'h8000, 1'b0, 8'h00, 1'b0);
        chk("run_high", run_s, 1'b1);
        access(1'b0, 16'hFE10, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("unmapped_zero", last_rd, 16'h0000);
        access(1'b0, 16'hFDFF, 16'h0000, 1'b0, 8'h00, 1'b0);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0);

        // reset in the middle of an SRAM wait, instance B
        sel = 1'b1;
        access(1'b1, 16'hFFFE, 16'h0000, 1'b0, 8'h00, 1'b0);
        access(1'b1, 16'hFE00, 16'h4000, 1'b0, 8'h00, 1'b0);
        events(1'b1, 8'h55, 1'b0);
        chk("b_kbint_pre", kbint_s, 1'b1);
        mem_en = 1'b1; mem_we = 1'b0; addr_d = 16'h2000;
        @(negedge clk);
        chk("b_ce_cycle1", ce_s, 1'b1);
        @(negedge clk);
        rst_b = 1'b0; mem_en = 1'b0;
        #1;
        chk("b_rst_ce", ce_s, 1'b0);
        chk("b_rst_ready", ready_s, 1'b0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready_s || ce_s) seen = 1'b1;
        end
        rst_b = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ready_s) seen = 1'b1;
        end
        chk("b_no_ready_after_abort", seen, 1'b0);
        model_reset(1);
        check_outputs(1);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0);
        chk("b_kbsr_cleared", last_rd, 16'h0000);
        access(1'b0, 16'h2000, 16'h0000, 1'b0, 8'h00, 1'b0);

        // randomized mix on both instances
        for (int i = 0; i < 150; i++) begin
            sel   = 1'($urandom_range(0, 1));
            kind  = $urandom_range(0, 9);
            r_we  = 1'($urandom_range(0, 1));
            r_wd  = 16'($urandom);
            r_kbe = ($urandom_range(0, 3) == 0);
            r_dr  = ($urandom_range(0, 3) == 0);
            if (kind < 4) begin
                case ($urandom_range(0, 3))
                    0:       r_a = 16'hFDFF;
                    1:       r_a = 16'h0000;
                    default: r_a = 16'($urandom_range(0, 16'hFDFF));
                endcase
                access(r_we, r_a, r_wd, r_kbe, 8'($urandom), r_dr);
            end else if (kind < 9) begin
                r_a = dev_list[$urandom_range(0, 7)];
                access(r_we, r_a, r_wd, r_kbe, 8'($urandom), r_dr);
            end else begin
                events(r_kbe, 8'($urandom), r_dr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
Memory/IO bridge directly downstream of the eLC-3 datapath's MAR/MDR. It takes the datapath's memory request (address from MAR, write data from MDR, MIO_EN and R.W from the control unit) and completes it against either a fixed-latency SRAM or the memory-mapped device registers. It returns read data to the MDR input and a one-cycle Ready (R) pulse that the control FSM waits on. It also owns the keyboard, display and machine-control registers.

Parameters:
READ_LATENCY, 2, SRAM cycles from CE to valid Sram_Rdata (legal range 1..15)
WRITE_LATENCY, 1, SRAM cycles a write occupies (legal range 1..15)
IO_BASE, 16'hFE00, addresses >= IO_BASE decode as device space

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Mem_En  in  1  request (MIO_EN); level, held by control unit until Ready
Mem_WE  in  1  1=write, 0=read (R.W)
Address  in  16  from MAR
Data_In  in  16  write data from MDR
Data_Out  out  16  read data to datapath In
Ready  out  1  one-cycle completion pulse (R)
Sram_Addr  out  16  SRAM address
Sram_Wdata  out  16  SRAM write data
Sram_Rdata  in  16  SRAM read data
Sram_CE  out  1  SRAM access strobe, one cycle per access
Sram_WE  out  1  SRAM write enable, qualified by Sram_CE
Kb_Valid  in  1  keyboard character strobe, one cycle
Kb_Data  in  8  keyboard character
Dsp_Data  out  8  display character
Dsp_Valid  out  1  display character pending
Dsp_Ready  in  1  display accepts when Dsp_Valid & Dsp_Ready
Kb_Int  out  1  KBSR[15] & KBSR[14]
Run  out  1  MCR[15]; 0 halts the CPU clock enable

Behaviour:
- Reset (async, Reset=0): state IDLE; Ready=0; Sram_CE=0; Sram_WE=0; Data_Out=0; Sram_Addr=0; Sram_Wdata=0; KBSR=0; KBDR=0; Dsp_Valid=0; Dsp_Data=0; Run=1.
- Reset mid-access aborts it. No Ready is issued and no register update occurs.
- FSM states: IDLE, SRAM_WAIT, DONE.
- IDLE: when Mem_En=1, latch Address, Data_In and Mem_WE.
  - Device space: go to DONE.
  - SRAM space: go to SRAM_WAIT and load the wait counter with READ_LATENCY or WRITE_LATENCY.
- SRAM_WAIT: Sram_CE=1 and Sram_WE=latched WE in the first SRAM_WAIT cycle only. Sram_Addr/Wdata stay stable for the whole wait. The counter decrements each cycle; at count 1, reads capture Sram_Rdata into Data_Out, then go to DONE.
- DONE: Ready=1 for exactly one cycle, then IDLE. Mem_En is ignored in DONE; the next request is sampled in IDLE.
- Latency, counted from the Mem_En-high IDLE cycle (cycle 0):
  - Ready in cycle 1 for device accesses.
  - Ready in cycle 1+READ_LATENCY for SRAM reads.
  - Ready in cycle 1+WRITE_LATENCY for SRAM writes.
- Data_Out is valid in the Ready cycle and holds until the next read completes. Writes leave Data_Out unchanged.
- Device map, with device effects applied on the IDLE->DONE edge:
  - KBSR @IO_BASE+0: bit15 = char ready (RO); bit14 = interrupt enable (RW); other bits read 0.
  - KBDR @IO_BASE+2: read returns {8'h00, KBDR} and clears KBSR[15]. Writes are ignored.
  - DSR @IO_BASE+4: bit15 = ~Dsp_Valid (RO); other bits 0.
  - DDR @IO_BASE+6: write sets Dsp_Data=Data_In[7:0] and Dsp_Valid=1 only if Dsp_Valid=0; otherwise the write is dropped. Reads return 0.
  - MCR @16'hFFFE: bit15 RW and drives Run; other bits read 0.
  - Any other device-space address: reads return 0, writes are ignored, Ready is still issued.
- Keyboard: a Kb_Valid pulse with KBSR[15]=0 loads KBDR and sets KBSR[15]. With KBSR[15]=1 the character is dropped.
  - If Kb_Valid coincides with the edge of a KBDR read: the read returns the old KBDR, the new character is loaded, and KBSR[15] stays 1.
- Display: Dsp_Valid clears on the edge where Dsp_Valid & Dsp_Ready.
  - If a DDR write coincides with acceptance, the write is dropped, because Dsp_Valid is still 1 at sampling.
- Device register state updates and the Kb_Valid/Dsp_Ready handshakes run every cycle, independent of FSM state.
- Address wrap: none. All 16-bit addresses are decoded; 16'hFDFF is SRAM and 16'hFE00 is device space.

Test Plan:
- SRAM read, READ_LATENCY=2, Sram_Rdata=16'h1234 at Address 16'h3000, Mem_En cycle 0 -> Sram_CE=1 only in cycle 1, Ready=1 in cycle 3 only, Data_Out=16'h1234 and held afterwards.
- SRAM write 16'hBEEF to 16'h0040, WRITE_LATENCY=1 -> Sram_CE=Sram_WE=1 in cycle 1 with Sram_Addr=16'h0040 and Sram_Wdata=16'hBEEF, Ready in cycle 2, Data_Out unchanged.
- Keyboard path:
  - Kb_Valid with 8'h41 -> KBSR read returns 16'h8000, Kb_Int=0.
  - Write KBSR=16'h4000 -> Kb_Int=1.
  - KBDR read returns 16'h0041 and the next KBSR read returns 16'h4000.
  - A second Kb_Valid (8'h42) while KBSR[15]=1 is dropped.
- Display path:
  - Write DDR 16'h0058 with Dsp_Ready=0 -> Dsp_Valid=1, Dsp_Data=8'h58, DSR reads 16'h0000.
  - A second DDR write of 16'h0059 is dropped (Dsp_Data stays 8'h58).
  - Raise Dsp_Ready -> Dsp_Valid=0 and DSR reads 16'h8000.
- MCR write 16'h0000 -> Run=0 after Ready. Read of unmapped 16'hFE10 returns 16'h0000 with Ready in cycle 1.
- Drive Reset low during SRAM_WAIT (READ_LATENCY=4) -> Sram_CE=0 and Ready never pulses. After release, a fresh read completes normally and KBSR=0, Run=1.
